// File: rtl/kgp_alu_pkg.sv
// kgp_alu_pkg: shared mode constants, group width and stage record
// for the pipelined carry-lookahead adder.
package kgp_alu_pkg;

  localparam logic ADD     = 1'b0;
  localparam logic SUB     = 1'b1;
  localparam int   CLA_GRP = 4;
  localparam int   MAX_W   = 64;

  // b holds the mode-adjusted operand (in2 or ~in2)
  typedef struct packed {
    logic             valid;
    logic             mode;
    logic             carry;
    logic [MAX_W-1:0] psum;
    logic [MAX_W-1:0] a;
    logic [MAX_W-1:0] b;
  } stage_t;

endpackage

// File: rtl/cla_group4.sv
// cla_group4: combinational 4-bit lookahead group with
// group propagate/generate outputs.
module cla_group4
  import kgp_alu_pkg::*;
(
  input  logic [CLA_GRP-1:0] a,
  input  logic [CLA_GRP-1:0] b,
  input  logic               cin,
  output logic [CLA_GRP-1:0] s,
  output logic               gp,
  output logic               gg
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0])
              | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

  assign s  = p ^ c;
  assign gp = &p;
  assign gg = g[3] | (p[3] & g[2])
            | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/pipe_cla_adder.sv
// pipe_cla_adder: pipelined CLA add/sub with a global stall.
// Define PIPE_CLA_FLAGS_EN for registered overflow/zero flags.
module pipe_cla_adder
  import kgp_alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             sub,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NG  = WIDTH / CLA_GRP;
  localparam int GPS = NG / STAGES;
  localparam int SW  = GPS * CLA_GRP;

  stage_t            src [STAGES];
  stage_t            nxt [STAGES];
  stage_t            stg [STAGES];
  logic [WIDTH-1:0]  s_all;
  logic [STAGES-1:0] st_cout;
  logic              advance;
  logic              unused_par;

  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = stg[STAGES-1].valid;
  assign sum       = stg[STAGES-1].psum[WIDTH-1:0];
  assign c_out     = stg[STAGES-1].carry;

  always_comb begin
    src[0]       = '0;
    src[0].valid = in_valid;
    src[0].mode  = sub;
    src[0].carry = (sub == SUB) ? 1'b1 : c_in;
    src[0].a     = MAX_W'(in1);
    src[0].b     = MAX_W'((sub == ADD) ? in2 : ~in2);
    for (int k = 1; k < STAGES; k++) begin
      src[k] = stg[k-1];
    end
  end

  // each group reads the record entering the stage that owns it
  for (genvar g = 0; g < NG; g++) begin : grp
    logic       gcin;
    logic       gcout;
    logic       gp;
    logic       gg;
    logic [3:0] gs;

    if (g % GPS == 0) begin : head
      assign gcin = src[g/GPS].carry;
    end else begin : link
      assign gcin = grp[g-1].gcout;
    end

    cla_group4 u_grp (
      .a   (src[g/GPS].a[g*CLA_GRP +: CLA_GRP]),
      .b   (src[g/GPS].b[g*CLA_GRP +: CLA_GRP]),
      .cin (gcin),
      .s   (gs),
      .gp  (gp),
      .gg  (gg)
    );

    assign gcout = gg | (gp & gcin);
    assign s_all[g*CLA_GRP +: CLA_GRP] = gs;
  end

  for (genvar k = 0; k < STAGES; k++) begin : scar
    assign st_cout[k] = grp[(k+1)*GPS-1].gcout;
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      nxt[k]       = src[k];
      nxt[k].carry = st_cout[k];
      nxt[k].psum  =
        (src[k].psum & ~(MAX_W'({SW{1'b1}}) << (k*SW)))
        | (MAX_W'(s_all) & (MAX_W'({SW{1'b1}}) << (k*SW)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) stg[k] <= '0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) stg[k] <= nxt[k];
    end
  end

`ifdef PIPE_CLA_FLAGS_EN
  logic ovf_d;
  logic zero_d;
  logic ovf_q;
  logic zero_q;

  assign ovf_d =
    (src[STAGES-1].a[WIDTH-1] == src[STAGES-1].b[WIDTH-1])
    && (s_all[WIDTH-1] != src[STAGES-1].a[WIDTH-1]);
  assign zero_d = (nxt[STAGES-1].psum[WIDTH-1:0] == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (advance) begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign overflow = ovf_q;
  assign zero     = zero_q;
`else
  assign overflow = 1'b0;
  assign zero     = 1'b0;
`endif

  // upper record bits beyond WIDTH and the mode tag are not consumed
  always_comb begin
    unused_par = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      unused_par = unused_par ^ (^stg[k]);
    end
  end

endmodule

// File: tb/tb_pipe_cla_adder.sv
// tb_pipe_cla_adder: randomized and directed bench for pipe_cla_adder
// against an arithmetic reference model (WIDTH=32, STAGES=2).
module tb_pipe_cla_adder;

  localparam int W = 32;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         sub;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         overflow;
  logic         zero;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  pipe_cla_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .sub       (sub),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input logic sb,
                                 input logic ci);
    exp_t   e;
    longint ua, ub, sa, sbv, r, sr;
    logic   ov;
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (sb) begin
      r   = ua - ub;
      e.c = (ua >= ub);
      sr  = sa - sbv;
    end else begin
      r   = ua + ub + longint'(ci);
      e.c = r[W];
      sr  = sa + sbv + longint'(ci);
    end
    e.s = r[W-1:0];
    ov  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
`ifdef PIPE_CLA_FLAGS_EN
    e.v = ov;
    e.z = (e.s == '0);
`else
    e.v = 1'b0;
    e.z = 1'b0;
    if (ov) e.v = 1'b0;
`endif
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sb, input logic ci, input logic v);
    in1      = a;
    in2      = b;
    sub      = sb;
    c_in     = ci;
    in_valid = v;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive('0, '0, 1'b0, 1'b0, 1'b0);
    cyc();
    checks++;
    if ({out_valid, sum, c_out, overflow, zero} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b s=%h c=%b o=%b z=%b want all 0",
               out_valid, sum, c_out, overflow, zero);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [5];
    logic [W-1:0] tb [5];
    logic         tsb[5];
    logic         tci[5];
    logic [W-1:0] ts [5];
    logic         tc [5];
    exp_t         e;
    ta = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h5, 32'h7, 32'h1};
    tb = '{32'h00000001, 32'h00000001, 32'h7, 32'h5, 32'h1};
    tsb = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tci = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    ts = '{32'h0, 32'h80000000, 32'hFFFFFFFE, 32'h2, 32'h3};
    tc = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      e = model(ta[i], tb[i], tsb[i], tci[i]);
      drive(ta[i], tb[i], tsb[i], tci[i], 1'b1);
      cyc();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL dir%0d_early_valid got %b want 0", i, out_valid);
      end
      cyc();
      checks++;
      if (out_valid !== 1'b1 || sum !== ts[i] || c_out !== tc[i]) begin
        failures++;
        $display("FAIL dir%0d_result got v=%b s=%h c=%b want v=1 s=%h c=%b",
                 i, out_valid, sum, c_out, ts[i], tc[i]);
      end
      checks++;
      if (overflow !== e.v || zero !== e.z) begin
        failures++;
        $display("FAIL dir%0d_flags got o=%b z=%b want o=%b z=%b",
                 i, overflow, zero, e.v, e.z);
      end
      cyc();
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL dir%0d_retire got v=%b want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t         q[$];
    exp_t         h;
    logic [W-1:0] av[4];
    logic [W-1:0] bv[4];
    logic [W-1:0] held;
    int           idx   = 0;
    int           got   = 0;
    int           stall = 0;
    bit           seen  = 1'b0;
    bit           acc, ret;
    for (int i = 0; i < 4; i++) begin
      av[i] = $urandom;
      bv[i] = $urandom;
    end
    held = '0;
    for (int c = 0; c < 30 && got < 4; c++) begin
      if (out_valid && !seen) begin
        seen = 1'b1;
        held = sum;
      end
      out_ready = !(seen && stall < 3);
      if (idx < 4) drive(av[idx], bv[idx], 1'(idx), 1'b1, 1'b1);
      else in_valid = 1'b0;
      #1;
      if (!out_ready) begin
        stall++;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || sum !== held
            || q.size() == 0 || sum !== q[0].s) begin
          failures++;
          $display("FAIL b2b_stall got rdy=%b v=%b s=%h want rdy=0 v=1 s=%h",
                   in_ready, out_valid, sum, held);
        end
      end
      acc = in_valid && in_ready;
      ret = out_valid && out_ready;
      if (ret) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL b2b_spurious got s=%h want no beat", sum);
        end else begin
          h = q.pop_front();
          if ({sum, c_out, overflow, zero} !== {h.s, h.c, h.v, h.z}) begin
            failures++;
            $display("FAIL b2b_order got s=%h c=%b want s=%h c=%b",
                     sum, c_out, h.s, h.c);
          end
        end
        got++;
      end
      if (acc) begin
        q.push_back(model(av[idx], bv[idx], 1'(idx), 1'b1));
        idx++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 4 || idx != 4 || q.size() != 0 || stall != 3) begin
      failures++;
      $display("FAIL b2b_count got out=%0d in=%0d stall=%0d want 4 4 3",
               got, idx, stall);
    end
    out_ready = 1'b1;
    cyc();
  endtask

  task automatic test_random();
    exp_t         q[$];
    exp_t         h;
    logic [W-1:0] a, b;
    logic [31:0]  r;
    int           acc_n = 0;
    bit           acc, ret;
    for (int c = 0; c < 400; c++) begin
      r = $urandom;
      a = $urandom;
      b = $urandom;
      if (r[7:6] == 2'b00) a = '1;
      if (r[9:8] == 2'b00) b = a;
      out_ready = (c < 20) ? 1'b1 : (r[1:0] != 2'b00);
      drive(a, b, r[2], r[3], (c < 20) ? 1'b1 : r[4]);
      #1;
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        failures++;
        $display("FAIL rnd_in_ready got %b want %b",
                 in_ready, !out_valid || out_ready);
      end
      acc = in_valid && in_ready;
      ret = out_valid && out_ready;
      if (ret) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL rnd_spurious got s=%h want no beat", sum);
        end else begin
          h = q.pop_front();
          if ({sum, c_out, overflow, zero} !== {h.s, h.c, h.v, h.z}) begin
            failures++;
            $display("FAIL rnd_result got s=%h c=%b o=%b z=%b want s=%h c=%b o=%b z=%b",
                     sum, c_out, overflow, zero, h.s, h.c, h.v, h.z);
          end
        end
      end
      if (acc) begin
        q.push_back(model(a, b, r[2], r[3]));
        if (c < 20) acc_n++;
      end
      @(posedge clk);
      #1;
      if (c == 19) begin
        checks++;
        if (acc_n != 20 || q.size() != S) begin
          failures++;
          $display("FAIL rnd_throughput got acc=%0d inflight=%0d want 20 %0d",
                   acc_n, q.size(), S);
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && q.size() > 0; c++) begin
      #1;
      if (out_valid) begin
        h = q.pop_front();
        checks++;
        if ({sum, c_out, overflow, zero} !== {h.s, h.c, h.v, h.z}) begin
          failures++;
          $display("FAIL rnd_drain got s=%h want s=%h", sum, h.s);
        end
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rnd_drain_empty got left=%0d v=%b want 0 0",
               q.size(), out_valid);
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1;
    drive(32'd3, 32'd4, 1'b0, 1'b0, 1'b1);
    cyc();
    drive(32'd5, 32'd6, 1'b0, 1'b0, 1'b1);
    cyc();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || sum !== '0 || c_out !== 1'b0
        || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_async got v=%b s=%h c=%b rdy=%b want 0 0 0 1",
               out_valid, sum, c_out, in_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(32'd1, 32'd1, 1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_accept got rdy=%b want 1", in_ready);
    end
    cyc();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_stale got v=%b s=%h want v=0", out_valid, sum);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b1 || sum !== 32'd2 || c_out !== 1'b0) begin
      failures++;
      $display("FAIL rst_next got v=%b s=%h c=%b want v=1 s=2 c=0",
               out_valid, sum, c_out);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_after got v=%b want 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
